// File: rtl/button_count_ctrl.sv
// Up/down counter stepped by debounced buttons: one step per press, auto-repeat
// while held, saturating or wrapping limits, and a preset load.
module button_count_ctrl #(
  parameter int WIDTH         = 8,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 255,
  parameter int STEP          = 1,
  parameter int RESET_VAL     = 0,
  parameter int PRESET_VAL    = 22,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_preset,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             step_pulse,
  output logic             limit_hit,
  output logic [1:0]       fsm_state
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [WIDTH:0]   MIN_E       = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_E       = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_E      = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   RANGE_E     = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);
  localparam logic [TW-1:0]    HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH-1:0] RESET_W     = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] PRESET_W    = WIDTH'(PRESET_VAL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  state_t        state;
  dir_t          dir;
  logic [TW-1:0] timer;
  logic          up_q;
  logic          down_q;
  logic          preset_q;
  // Low for the first clock after reset so a button held across reset
  // release is only sampled into history, never treated as a press.
  logic          live;

  logic           up_press;
  logic           down_press;
  logic           preset_press;
  logic           both_held;
  logic           dir_held;
  logic           step_up;
  logic [WIDTH:0] cnt_e;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] down_floor;
  logic [WIDTH:0] res_e;
  logic           res_clamp;
  logic           res_changed;
  logic           res_at_max;
  logic           res_at_min;

  assign up_press     = btn_up & ~up_q;
  assign down_press   = btn_down & ~down_q;
  assign preset_press = btn_preset & ~preset_q;
  assign both_held    = btn_up & btn_down;
  assign dir_held     = (dir == DIR_UP) ? btn_up : btn_down;
  assign step_up      = (state == S_IDLE) ? up_press : (dir == DIR_UP);
  assign fsm_state    = state;

  assign cnt_e      = {1'b0, count};
  assign up_sum     = cnt_e + STEP_E;
  assign down_floor = MIN_E + STEP_E;

  // Candidate result of one step in the selected direction; all sums fit in
  // WIDTH+1 bits because MAX_VAL < 2**WIDTH and STEP <= MAX_VAL-MIN_VAL.
  always_comb begin
    res_e     = cnt_e;
    res_clamp = 1'b0;
    if (step_up) begin
      if (up_sum > MAX_E) begin
        if (wrap_en) begin
          res_e = up_sum - RANGE_E;
        end else begin
          res_e     = MAX_E;
          res_clamp = 1'b1;
        end
      end else begin
        res_e = up_sum;
      end
    end else begin
      if (cnt_e < down_floor) begin
        if (wrap_en) begin
          res_e = cnt_e + RANGE_E - STEP_E;
        end else begin
          res_e     = MIN_E;
          res_clamp = 1'b1;
        end
      end else begin
        res_e = cnt_e - STEP_E;
      end
    end
  end

  assign res_changed = (res_e != cnt_e);
  assign res_at_max  = (res_e == MAX_E);
  assign res_at_min  = (res_e == MIN_E);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= RESET_W;
      at_max     <= (RESET_VAL == MAX_VAL);
      at_min     <= (RESET_VAL == MIN_VAL);
      step_pulse <= 1'b0;
      limit_hit  <= 1'b0;
      state      <= S_IDLE;
      dir        <= DIR_UP;
      timer      <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      preset_q   <= 1'b0;
      live       <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      limit_hit  <= 1'b0;
      up_q       <= btn_up;
      down_q     <= btn_down;
      preset_q   <= btn_preset;
      live       <= 1'b1;
      if (live) begin
        if (preset_press) begin
          count      <= PRESET_W;
          at_max     <= (PRESET_VAL == MAX_VAL);
          at_min     <= (PRESET_VAL == MIN_VAL);
          step_pulse <= (count != PRESET_W);
          state      <= S_IDLE;
          timer      <= '0;
        end else if (both_held) begin
          state <= S_IDLE;
          timer <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              if (up_press || down_press) begin
                count      <= res_e[WIDTH-1:0];
                at_max     <= res_at_max;
                at_min     <= res_at_min;
                step_pulse <= res_changed;
                limit_hit  <= res_clamp;
                dir        <= up_press ? DIR_UP : DIR_DOWN;
                timer      <= '0;
                state      <= S_ARMED;
              end
            end
            S_ARMED: begin
              if (!dir_held) begin
                state <= S_IDLE;
                timer <= '0;
              end else if (timer == HOLD_LAST) begin
                count      <= res_e[WIDTH-1:0];
                at_max     <= res_at_max;
                at_min     <= res_at_min;
                step_pulse <= res_changed;
                limit_hit  <= res_clamp;
                timer      <= '0;
                state      <= S_REPEAT;
              end else begin
                timer <= timer + TW'(1);
              end
            end
            S_REPEAT: begin
              if (!dir_held) begin
                state <= S_IDLE;
                timer <= '0;
              end else if (timer == REPEAT_LAST) begin
                count      <= res_e[WIDTH-1:0];
                at_max     <= res_at_max;
                at_min     <= res_at_min;
                step_pulse <= res_changed;
                limit_hit  <= res_clamp;
                timer      <= '0;
              end else begin
                timer <= timer + TW'(1);
              end
            end
            default: begin
              state <= S_IDLE;
              timer <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule
